// File: rtl/multdiv_iter.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, followed by a sign/accumulate fix-up.
module multdiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e            state_q;
  logic [2:0]        op_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  opnd_q;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]  work_hi_q;  // product high half / partial remainder
  logic [WIDTH-1:0]  work_lo_q;  // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0]  base_hi_q;
  logic [WIDTH-1:0]  base_lo_q;
  logic              neg_res_q;
  logic              neg_rem_q;

  // Launch-side operand decode
  logic             in_div;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    in_div = (op[2:1] == 2'b01);
    a_neg  = ~op[0] & a[WIDTH-1];
    b_neg  = ~op[0] & b[WIDTH-1];
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
  end

  // One iteration of shift-add or restoring division
  logic             q_div;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] div_trial;
  logic             div_ok;
  logic [WIDTH-1:0] next_hi;
  logic [WIDTH-1:0] next_lo;

  always_comb begin
    q_div     = (op_q[2:1] == 2'b01);
    mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = {1'b0, work_hi_q, work_lo_q[WIDTH-1]} - {2'b00, opnd_q};
    div_ok    = ~div_trial[WIDTH+1];
    if (q_div) begin
      next_hi = div_ok ? div_trial[WIDTH-1:0] : {work_hi_q[WIDTH-2:0], work_lo_q[WIDTH-1]};
      next_lo = {work_lo_q[WIDTH-2:0], div_ok};
    end else begin
      next_hi = mul_sum[WIDTH:1];
      next_lo = {mul_sum[0], work_lo_q[WIDTH-1:1]};
    end
  end

  // Sign correction and accumulate, consumed at commit
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] sprod;
  logic [2*WIDTH-1:0] base;
  logic [2*WIDTH-1:0] mac;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  always_comb begin
    prod  = {work_hi_q, work_lo_q};
    sprod = neg_res_q ? -prod : prod;
    base  = {base_hi_q, base_lo_q};
    if (!op_q[2]) begin
      mac = sprod;
    end else if (op_q[1]) begin
      mac = base - sprod;
    end else begin
      mac = base + sprod;
    end
    if (q_div) begin
      res_hi = neg_rem_q ? -work_hi_q : work_hi_q;
      res_lo = neg_res_q ? -work_lo_q : work_lo_q;
    end else begin
      res_hi = mac[2*WIDTH-1:WIDTH];
      res_lo = mac[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      op_q      <= '0;
      cnt_q     <= '0;
      opnd_q    <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      base_hi_q <= '0;
      base_lo_q <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      // Register writes; a commit on the same edge overrides below
      if (hi_we) hi <= a;
      if (lo_we) lo <= a;
      if (flush) begin
        state_q <= StIdle;
        busy    <= 1'b0;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              if (in_div && (b == '0)) begin
                div_zero <= 1'b1;
              end else begin
                state_q   <= StCalc;
                busy      <= 1'b1;
                cnt_q     <= '0;
                op_q      <= op;
                neg_res_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
                base_hi_q <= hi;
                base_lo_q <= lo;
                work_hi_q <= '0;
                opnd_q    <= in_div ? b_mag : a_mag;
                work_lo_q <= in_div ? a_mag : b_mag;
              end
            end
          end
          StCalc: begin
            work_hi_q <= next_hi;
            work_lo_q <= next_lo;
            cnt_q     <= cnt_q + CntW'(1);
            if (cnt_q == CntLast) begin
              state_q <= StFix;
              cnt_q   <= '0;
            end
          end
          StFix: begin
            hi      <= res_hi;
            lo      <= res_lo;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_iter.sv
// Self-checking bench for multdiv_iter (WIDTH=32) against a plain-arithmetic HI/LO model.
module tb_multdiv_iter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic         flush = 1'b0;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] mhi = '0;
  logic [W-1:0] mlo = '0;

  multdiv_iter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .flush(flush), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // Reference result {HI,LO} from the arithmetic definition of each op
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input logic [31:0] bh,
                                         input logic [31:0] bl);
    longint sx, sy;
    logic [63:0] sp, up, base;
    logic [31:0] q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sp = 64'(sx * sy);
    up = {32'd0, x} * {32'd0, y};
    base = {bh, bl};
    q = '0;
    r = '0;
    case (o)
      3'd0: return sp;
      3'd1: return up;
      3'd2: begin q = 32'(sx / sy); r = 32'(sx % sy); return {r, q}; end
      3'd3: return {x % y, x / y};
      3'd4: return base + sp;
      3'd5: return base + up;
      3'd6: return base - sp;
      default: return base - up;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the first negedge after the start edge (k=1); returns at the done-high negedge
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic mt(input logic [31:0] h, input logic [31:0] l);
    a = h; hi_we = 1'b1;
    @(negedge clk);
    hi_we = 1'b0; a = l; lo_we = 1'b1;
    @(negedge clk);
    lo_we = 1'b0;
    mhi = h;
    mlo = l;
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, div_zero} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got %b expected 000", {busy, done, div_zero});
    end
    n_checks++;
    if ({hi, lo} !== 64'd0) begin
      n_fail++; $display("FAIL reset_hilo got %h expected 0", {hi, lo});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult;
    int lat, bc;
    logic [63:0] e;
    e = ref_op(3'd0, 32'hFFFFFFFD, 32'd7, mhi, mlo);
    issue(3'd0, 32'hFFFFFFFD, 32'd7);
    wait_done(lat, bc);
    {mhi, mlo} = e;
    n_checks++;
    if (lat !== W + 2) begin n_fail++; $display("FAIL mult_latency got %0d expected %0d", lat, W + 2); end
    n_checks++;
    if (bc !== W + 1) begin n_fail++; $display("FAIL mult_busy_cycles got %0d expected %0d", bc, W + 1); end
    n_checks++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
      n_fail++; $display("FAIL mult_result got %h expected ffffffffffffffeb", {hi, lo});
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse got %b expected 0", done); end
  endtask

  task automatic test_reset_mid_calc;
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, div_zero, hi, lo} !== '0) begin
      n_fail++; $display("FAIL reset_mid_calc got busy=%b hi=%h lo=%h expected all 0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b1;
    mhi = '0;
    mlo = '0;
    repeat (40) @(negedge clk);
    n_checks++;
    if ({busy, hi, lo} !== '0) begin
      n_fail++; $display("FAIL reset_mid_calc_after got busy=%b hi=%h lo=%h expected 0", busy, hi, lo);
    end
  endtask

  task automatic test_mult_div_cases;
    logic [2:0]  ops[3] = '{3'd1, 3'd2, 3'd2};
    logic [31:0] as[3]  = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000};
    logic [31:0] bs[3]  = '{32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF};
    logic [63:0] exp_c[3] = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFFD, 64'h00000000_80000000};
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_done(lat, bc);
      {mhi, mlo} = exp_c[i];
      n_checks++;
      if ({hi, lo} !== exp_c[i]) begin
        n_fail++; $display("FAIL case%0d_result got %h expected %h", i, {hi, lo}, exp_c[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero;
    issue(3'd3, 32'd7, 32'd0);
    n_checks++;
    if ({div_zero, busy} !== 2'b10) begin
      n_fail++; $display("FAIL divzero_pulse got dz=%b busy=%b expected dz=1 busy=0", div_zero, busy);
    end
    @(negedge clk);
    n_checks++;
    if ({div_zero, busy, done} !== 3'b000) begin
      n_fail++; $display("FAIL divzero_clear got %b expected 000", {div_zero, busy, done});
    end
    n_checks++;
    if ({hi, lo} !== {mhi, mlo}) begin
      n_fail++; $display("FAIL divzero_hilo got %h expected %h", {hi, lo}, {mhi, mlo});
    end
  endtask

  task automatic test_madd_msub;
    int lat, bc;
    mt(32'd0, 32'd10);
    n_checks++;
    if ({hi, lo} !== {32'd0, 32'd10}) begin
      n_fail++; $display("FAIL mthi_mtlo got %h expected %h", {hi, lo}, {32'd0, 32'd10});
    end
    issue(3'd4, 32'hFFFFFFFE, 32'd3);
    wait_done(lat, bc);
    {mhi, mlo} = ref_op(3'd4, 32'hFFFFFFFE, 32'd3, mhi, mlo);
    n_checks++;
    if ({hi, lo} !== 64'd4) begin n_fail++; $display("FAIL madd got %h expected 4", {hi, lo}); end
    @(negedge clk);
    issue(3'd7, 32'd5, 32'd1);
    wait_done(lat, bc);
    {mhi, mlo} = ref_op(3'd7, 32'd5, 32'd1, mhi, mlo);
    n_checks++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFF) begin
      n_fail++; $display("FAIL msubu got %h expected ffffffffffffffff", {hi, lo});
    end
    @(negedge clk);
  endtask

  task automatic test_flush;
    int ndone;
    issue(3'd0, 32'd1234, 32'd5678);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b expected 0", busy); end
    // flush beats a start in the same cycle
    flush = 1'b1;
    issue(3'd1, 32'd9, 32'd9);
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy got %b expected 0", busy); end
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    n_checks++;
    if (ndone !== 0) begin n_fail++; $display("FAIL flush_no_done got %0d expected 0", ndone); end
    n_checks++;
    if ({hi, lo} !== {mhi, mlo}) begin
      n_fail++; $display("FAIL flush_hilo got %h expected %h", {hi, lo}, {mhi, mlo});
    end
  endtask

  task automatic test_ignore_busy;
    int lat, bc, ndone;
    issue(3'd0, 32'd3, 32'd4);
    repeat (3) @(negedge clk);
    issue(3'd1, 32'd100, 32'd200);
    wait_done(lat, bc);
    {mhi, mlo} = ref_op(3'd0, 32'd3, 32'd4, mhi, mlo);
    n_checks++;
    if ({hi, lo} !== {mhi, mlo}) begin
      n_fail++; $display("FAIL ignore_busy_result got %h expected %h", {hi, lo}, {mhi, mlo});
    end
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    n_checks++;
    if (ndone !== 0) begin n_fail++; $display("FAIL ignore_busy_second got %0d expected 0", ndone); end
  endtask

  task automatic test_mtlo_during;
    int lat, bc;
    issue(3'd1, 32'd2, 32'd3);
    repeat (4) @(negedge clk);
    a = 32'h55; lo_we = 1'b1;
    @(negedge clk);
    lo_we = 1'b0;
    n_checks++;
    if (lo !== 32'h55) begin n_fail++; $display("FAIL mtlo_busy got %h expected 55", lo); end
    wait_done(lat, bc);
    {mhi, mlo} = 64'd6;
    n_checks++;
    if ({hi, lo} !== 64'd6) begin n_fail++; $display("FAIL mtlo_commit got %h expected 6", {hi, lo}); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    logic [63:0] e;
    issue(3'd0, 32'h0001_0003, 32'hFFFF_FFF0);
    wait_done(lat, bc);
    {mhi, mlo} = ref_op(3'd0, 32'h0001_0003, 32'hFFFF_FFF0, mhi, mlo);
    e = ref_op(3'd4, 32'd1000, 32'd77, mhi, mlo);
    issue(3'd4, 32'd1000, 32'd77);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got %b expected 1", busy); end
    wait_done(lat, bc);
    {mhi, mlo} = e;
    n_checks++;
    if (lat !== W + 2) begin n_fail++; $display("FAIL b2b_latency got %0d expected %0d", lat, W + 2); end
    n_checks++;
    if ({hi, lo} !== e) begin n_fail++; $display("FAIL b2b_result got %h expected %h", {hi, lo}, e); end
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick;
    case ($urandom_range(0, 5))
      0: return 32'h80000000;
      1: return 32'hFFFFFFFF;
      2: return 32'd1;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random;
    int lat, bc;
    logic [2:0]  o;
    logic [31:0] x, y;
    logic [63:0] e;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) mt($urandom, $urandom);
      o = 3'($urandom_range(0, 7));
      x = pick();
      y = pick();
      if (o[2:1] == 2'b01 && y == 32'd0) y = 32'd3;
      e = ref_op(o, x, y, mhi, mlo);
      issue(o, x, y);
      wait_done(lat, bc);
      {mhi, mlo} = e;
      n_checks++;
      if (lat !== W + 2) begin
        n_fail++; $display("FAIL rand%0d_latency op=%0d got %0d expected %0d", i, o, lat, W + 2);
      end
      n_checks++;
      if ({hi, lo} !== e) begin
        n_fail++;
        $display("FAIL rand%0d_result op=%0d a=%h b=%h got %h expected %h", i, o, x, y, {hi, lo}, e);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_reset_mid_calc;
    test_mult_div_cases;
    test_div_zero;
    test_madd_msub;
    test_flush;
    test_ignore_busy;
    test_mtlo_during;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
